// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: a single 1-bit subtract cell walks the operands
// LSB first, one bit per clock, and presents diff/borrow/ovf/zero with a
// valid/ready handshake. Latency from accept to out_valid is WIDTH edges.
module serial_subtractor #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             ovf,
   output logic             zero,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int IDXW = $clog2(WIDTH);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // One-bit subtract cell: returns {borrow_out, difference_bit}.
   function automatic logic [1:0] sub_cell(input logic a_bit,
                                           input logic b_bit,
                                           input logic br_in);
      logic d_bit;
      logic br_out;
      d_bit  = a_bit ^ b_bit ^ br_in;
      br_out = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_in);
      return {br_out, d_bit};
   endfunction

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [IDXW-1:0]  idx_q, idx_d;
   logic             br_q, br_d;
   logic             nz_q, nz_d;
   logic             borrow_q, borrow_d;
   logic             ovf_q, ovf_d;
   logic             zero_q, zero_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;

   logic             accept_s;
   logic             last_bit_s;
   logic [1:0]       cell_s;
   logic             cell_d_s;
   logic             cell_br_s;

   assign accept_s   = in_valid & (state_q == IDLE);
   assign last_bit_s = (idx_q == LAST_IDX);
   assign cell_s     = sub_cell(a_sh_q[0], b_sh_q[0], br_q);
   assign cell_d_s   = cell_s[0];
   assign cell_br_s  = cell_s[1];

   // Next-state logic for the IDLE/RUN/DONE sequencer.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept_s) begin
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (last_bit_s) begin
               state_d = DONE;
            end else begin
               state_d = RUN;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Datapath next values: load on accept, shift one bit per RUN cycle,
   // capture the flags on the final bit, hold everything otherwise.
   always_comb begin
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      diff_d   = diff_q;
      idx_d    = idx_q;
      br_d     = br_q;
      nz_d     = nz_q;
      borrow_d = borrow_q;
      ovf_d    = ovf_q;
      zero_d   = zero_q;
      case (state_q)
         IDLE: begin
            if (accept_s) begin
               a_sh_d = a;
               b_sh_d = b;
               idx_d  = '0;
               br_d   = 1'b0;
               nz_d   = 1'b0;
            end else begin
               a_sh_d = a_sh_q;
            end
         end
         RUN: begin
            a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
            b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
            diff_d = {cell_d_s, diff_q[WIDTH-1:1]};
            br_d   = cell_br_s;
            nz_d   = nz_q | cell_d_s;
            if (last_bit_s) begin
               // On the final bit the cell inputs are the operand MSBs.
               idx_d    = '0;
               borrow_d = cell_br_s;
               ovf_d    = (a_sh_q[0] ^ b_sh_q[0]) & (cell_d_s ^ a_sh_q[0]);
               zero_d   = ~(nz_q | cell_d_s);
            end else begin
               idx_d    = idx_q + IDXW'(1);
            end
         end
         DONE: begin
            a_sh_d = a_sh_q;
         end
         default: begin
            a_sh_d = a_sh_q;
         end
      endcase
   end

   // Handshake outputs are registered copies of the next-state decode.
   always_comb begin
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
   end

   // State register; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh_q      <= '0;
         b_sh_q      <= '0;
         diff_q      <= '0;
         idx_q       <= '0;
         br_q        <= 1'b0;
         nz_q        <= 1'b0;
         borrow_q    <= 1'b0;
         ovf_q       <= 1'b0;
         zero_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         a_sh_q      <= a_sh_d;
         b_sh_q      <= b_sh_d;
         diff_q      <= diff_d;
         idx_q       <= idx_d;
         br_q        <= br_d;
         nz_q        <= nz_d;
         borrow_q    <= borrow_d;
         ovf_q       <= ovf_d;
         zero_q      <= zero_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign diff      = diff_q;
   assign borrow    = borrow_q;
   assign ovf       = ovf_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=4): directed vectors,
// backpressure, mid-operation reset and a randomized regression.
module tb_serial_subtractor;

   localparam int WIDTH = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [WIDTH-1:0] a = '0;
   logic [WIDTH-1:0] b = '0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] diff;
   logic             borrow;
   logic             ovf;
   logic             zero;
   logic             out_valid;
   logic             out_ready = 1'b0;

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a         (a),
      .b         (b),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .diff      (diff),
      .borrow    (borrow),
      .ovf       (ovf),
      .zero      (zero),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] d;
      logic       br;
      logic       ov;
      logic       z;
      int         acc;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_fail = 0;
   int   cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: plain integer arithmetic on the operand values.
   function automatic exp_t model(input int va, input int vb);
      exp_t e;
      int   sa, sb, r;
      e.d  = 4'((va - vb + 16) % 16);
      e.br = (va < vb);
      sa   = (va >= 8) ? va - 16 : va;
      sb   = (vb >= 8) ? vb - 16 : vb;
      r    = sa - sb;
      e.ov = (r > 7) || (r < -8);
      e.z  = ((va - vb + 16) % 16) == 0;
      e.acc = 0;
      return e;
   endfunction

   // Monitor: latency, stability under stall, and scoreboard pops.
   logic       pv = 1'b0;
   logic       pr = 1'b0;
   logic [3:0] s_d;
   logic       s_br, s_ov, s_z;
   always @(negedge clk) begin
      #1;
      if (!rst_n) begin
         pv = 1'b0;
         pr = 1'b0;
      end else begin
         check("ready_valid_exclusive", 32'(in_ready & out_valid), 32'd0);
         if (out_valid && !pv) begin
            if (sb_q.size() == 0) check("unexpected_out_valid", 32'(out_valid), 32'd0);
            else check("latency_cycle", cyc, sb_q[0].acc + WIDTH);
         end
         if (out_valid && pv && !pr) begin
            check("stall_diff", 32'(diff), 32'(s_d));
            check("stall_borrow", 32'(borrow), 32'(s_br));
            check("stall_ovf", 32'(ovf), 32'(s_ov));
            check("stall_zero", 32'(zero), 32'(s_z));
         end
         if (out_valid && out_ready && sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check("diff", 32'(diff), 32'(e.d));
            check("borrow", 32'(borrow), 32'(e.br));
            check("ovf", 32'(ovf), 32'(e.ov));
            check("zero", 32'(zero), 32'(e.z));
         end
         pv = out_valid;
         pr = out_ready;
         s_d = diff; s_br = borrow; s_ov = ovf; s_z = zero;
      end
   end

   task automatic wait_ready();
      int w;
      w = 0;
      @(negedge clk);
      while (!in_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
   endtask

   task automatic send(input logic [3:0] va, input logic [3:0] vb,
                       input logic [3:0] ed, input logic eb, input logic eo, input logic ez);
      exp_t e;
      wait_ready();
      a = va; b = vb; in_valid = 1'b1;
      e.d = ed; e.br = eb; e.ov = eo; e.z = ez; e.acc = cyc + 1;
      sb_q.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic drain(input int limit);
      int w;
      w = 0;
      while (sb_q.size() != 0 && w < limit) begin
         @(negedge clk);
         w++;
      end
      if (sb_q.size() != 0) check("drain_timeout", sb_q.size(), 32'd0);
   endtask

   initial begin
      exp_t e;
      int   ops, guard;

      // Reset values while rst_n is low.
      repeat (2) @(negedge clk);
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_diff", 32'(diff), 32'd0);
      check("rst_flags", {29'd0, borrow, ovf, zero}, 32'd0);

      // Release and accept on the first edge after release.
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      a = 4'd6; b = 4'd3; in_valid = 1'b1;
      e.d = 4'd3; e.br = 1'b0; e.ov = 1'b0; e.z = 1'b0; e.acc = cyc + 1;
      sb_q.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
      drain(50);

      // Directed vectors.
      send(4'd4,  4'd11, 4'd9,  1'b1, 1'b1, 1'b0); drain(50);
      send(4'd14, 4'd15, 4'd15, 1'b1, 1'b0, 1'b0); drain(50);
      send(4'd5,  4'd5,  4'd0,  1'b0, 1'b0, 1'b1); drain(50);
      send(4'd0,  4'd1,  4'd15, 1'b1, 1'b0, 1'b0); drain(50);
      send(4'd8,  4'd1,  4'd7,  1'b0, 1'b1, 1'b0); drain(50);

      // Backpressure: hold result for 7 cycles while inputs toggle.
      out_ready = 1'b0;
      send(4'd6, 4'd3, 4'd3, 1'b0, 1'b0, 1'b0);
      guard = 0;
      while (!out_valid && guard < 50) begin
         @(negedge clk);
         #1;
         guard++;
      end
      check("bp_out_valid_seen", 32'(out_valid), 32'd1);
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         in_valid = ~in_valid;
         a = 4'($urandom_range(0, 15));
         b = 4'($urandom_range(0, 15));
         #1;
         check("bp_in_ready", 32'(in_ready), 32'd0);
         check("bp_out_valid", 32'(out_valid), 32'd1);
      end
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      #1;
      check("bp_release_out_valid", 32'(out_valid), 32'd0);
      check("bp_release_in_ready", 32'(in_ready), 32'd1);
      check("bp_sb_empty", sb_q.size(), 32'd0);

      // Reset two cycles after accept: operation is discarded.
      wait_ready();
      a = 4'd9; b = 4'd2; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_in_ready", 32'(in_ready), 32'd1);
      check("abort_diff", 32'(diff), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      a = 4'd6; b = 4'd3; in_valid = 1'b1;
      e.d = 4'd3; e.br = 1'b0; e.ov = 1'b0; e.z = 1'b0; e.acc = cyc + 1;
      sb_q.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
      drain(50);

      // Randomized back-to-back regression with output stalls.
      ops = 0;
      guard = 0;
      while (ops < 1000 && guard < 40000) begin
         @(negedge clk);
         guard++;
         out_ready = ($urandom_range(0, 3) != 0);
         in_valid  = ($urandom_range(0, 4) != 0);
         a = 4'($urandom_range(0, 15));
         b = 4'($urandom_range(0, 15));
         if (in_valid && in_ready) begin
            e = model(int'(a), int'(b));
            e.acc = cyc + 1;
            sb_q.push_back(e);
            ops++;
         end
      end
      if (ops < 1000) check("random_ops_issued", ops, 32'd1000);
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      drain(100);
      repeat (3) @(negedge clk);
      check("final_sb_empty", sb_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
